// File: rtl/ecc_pkg.sv
// Shared ECC definitions: operand width, the secp256k1 field prime and the
// start/ready controller state encoding used by modmul and modinv.
package ecc_pkg;

    localparam int ECC_WIDTH = 256;

    localparam logic [ECC_WIDTH-1:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } modmul_state_t;

endpackage

// File: rtl/modmul_step.sv
// One interleaved (Blakley) bit-step: r' = (2r mod m + a_bit*b) mod m.
// Purely combinational; all work is done at WIDTH+1 bits so 2r and r+b never overflow.
module modmul_step
    import ecc_pkg::*;
#(
    parameter int WIDTH = ECC_WIDTH
) (
    input  logic [WIDTH:0]   r_i,
    input  logic             a_bit_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   r_o
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] dbl;
    logic [WIDTH:0] dbl_red;
    logic [WIDTH:0] sum;

    always_comb begin
        m_ext   = {1'b0, m_i};
        dbl     = r_i << 1;
        dbl_red = (dbl >= m_ext) ? (dbl - m_ext) : dbl;
        sum     = a_bit_i ? (dbl_red + {1'b0, b_i}) : dbl_red;
        r_o     = (sum >= m_ext) ? (sum - m_ext) : sum;
    end

endmodule

// File: rtl/modmul.sv
// Sequential modular multiplier c = a*b mod m, MSB-first over a, start/ready handshake.
// Define MODMUL_RADIX4_EN to retire two bits of a per cycle (WIDTH must then be even).
module modmul
    import ecc_pkg::*;
#(
    parameter int WIDTH = ECC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] c,
    output logic             ready
);

    localparam int CW = $clog2(WIDTH);

`ifdef MODMUL_RADIX4_EN
    localparam logic [CW-1:0] CNT_STEP = CW'(2);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);
`else
    localparam logic [CW-1:0] CNT_STEP = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(0);
`endif

    modmul_state_t    state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] c_q;
    logic             ready_q;

    // a_q is shifted left each cycle so the bit(s) being processed sit at the MSB end
`ifdef MODMUL_RADIX4_EN
    logic [WIDTH:0] r_mid;

    modmul_step #(.WIDTH(WIDTH)) u_step_hi (
        .r_i     (r_q),
        .a_bit_i (a_q[WIDTH-1]),
        .b_i     (b_q),
        .m_i     (m_q),
        .r_o     (r_mid)
    );

    modmul_step #(.WIDTH(WIDTH)) u_step_lo (
        .r_i     (r_mid),
        .a_bit_i (a_q[WIDTH-2]),
        .b_i     (b_q),
        .m_i     (m_q),
        .r_o     (r_d)
    );

    assign a_d = {a_q[WIDTH-3:0], 2'b00};
`else
    modmul_step #(.WIDTH(WIDTH)) u_step (
        .r_i     (r_q),
        .a_bit_i (a_q[WIDTH-1]),
        .b_i     (b_q),
        .m_i     (m_q),
        .r_o     (r_d)
    );

    assign a_d = {a_q[WIDTH-2:0], 1'b0};
`endif

    // Operand registers carry no reset: they are only meaningful while RUN.
    always_ff @(posedge clk) begin
        if (start && (state_q != RUN)) begin
            a_q <= a;
            b_q <= b;
            m_q <= m;
        end else if (state_q == RUN) begin
            a_q <= a_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= CW'(WIDTH - 1);
                        r_q     <= '0;
                        ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    r_q   <= r_d;
                    cnt_q <= cnt_q - CNT_STEP;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        c_q     <= r_d[WIDTH-1:0];
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign c     = c_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_modmul.sv
// Randomised scoreboard bench for modmul: a driver pushes a*b mod m (wide arithmetic)
// with the accept cycle, and a monitor checks result and latency on each rising ready.
module tb_modmul;
    import ecc_pkg::*;

    localparam int W = ECC_WIDTH;
`ifdef MODMUL_RADIX4_EN
    localparam int LAT = 128;
`else
    localparam int LAT = 256;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [W-1:0] m     = W'(2);
    logic [W-1:0] c;
    logic         ready;

    modmul dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .m     (m),
        .c     (c),
        .ready (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] c;
        int           t0;
        bit           chk_c;
    } exp_t;

    exp_t sb[$];
    bit   mon_rp = 1'b0;

    function automatic logic [W-1:0] ref_modmul(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic [W-1:0] mod);
        logic [2*W-1:0] xx, yy, mm, p;
        xx = {{W{1'b0}}, x};
        yy = {{W{1'b0}}, y};
        mm = {{W{1'b0}}, mod};
        p  = (xx * yy) % mm;
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W / 32; i++) v = {v[W-33:0], $urandom()};
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per rising edge of ready
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready && !mon_rp) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    if (e.chk_c) check("result", c, e.c);
                    check("latency", W'(cyc - e.t0), W'(LAT));
                end
            end
            mon_rp = ready;
        end
    end

    // Drives start into the edge that accepts it and records the expectation.
    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] mod,
                          input bit chk);
        exp_t e;
        a     = x;
        b     = y;
        m     = mod;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.c     = ref_modmul(x, y, mod);
        e.t0    = cyc;
        e.chk_c = chk;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < LAT + 20 && !seen; i++) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s timeout ready=0 required=1", name);
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] mod,
                          input bit chk, input string name);
        accept(x, y, mod, chk);
        @(negedge clk);
        start = 1'b0;
        a     = rand_word();
        b     = rand_word();
        m     = rand_word();
        wait_ready(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] x, y, mod;

        repeat (3) @(negedge clk);
        check("reset_c", c, '0);
        check("reset_ready", {{(W-1){1'b0}}, ready}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(W'(3), W'(5), W'(7), 1'b1, "small");
        run_op('0, W'(16'h1234), SECP256K1_P, 1'b1, "zero");
        run_op(W'(1), W'(16'h1234), SECP256K1_P, 1'b1, "identity");
        run_op(W'(2), 256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffff7ffffe18,
               SECP256K1_P, 1'b1, "inv_two");
        run_op(SECP256K1_P - W'(1), SECP256K1_P - W'(1), SECP256K1_P, 1'b1, "max_operands");

        // start pulse in the middle of a run must be ignored
        x = rand_word() % SECP256K1_P;
        y = rand_word() % SECP256K1_P;
        accept(x, y, SECP256K1_P, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        a     = rand_word();
        b     = rand_word();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ready("mid_start");

        // start held high across completion: back-to-back runs, one-cycle ready
        x = rand_word() % SECP256K1_P;
        y = rand_word() % SECP256K1_P;
        accept(x, y, SECP256K1_P, 1'b1);
        wait_ready("hold_first");
        accept(x, y, SECP256K1_P, 1'b1);
        @(negedge clk);
        check("hold_ready_pulse", {{(W-1){1'b0}}, ready}, '0);
        wait_ready("hold_second");
        start = 1'b0;
        @(negedge clk);
        check("done_ready_held", {{(W-1){1'b0}}, ready}, W'(1));

        for (int k = 0; k < 6; k++) begin
            if (k < 3) mod = rand_word() | W'(2);
            else       mod = W'($urandom_range(1000, 2));
            x = rand_word() % mod;
            y = rand_word() % mod;
            run_op(x, y, mod, 1'b1, "random");
        end

        // out-of-range multiplier: result undefined but the unit must still finish
        run_op(rand_word() | {1'b1, {(W-1){1'b0}}}, W'(9), W'(11), 1'b0, "bad_operand");

        run_op(W'(3), W'(5), W'(7), 1'b1, "pre_reset");
        accept(rand_word() % SECP256K1_P, rand_word() % SECP256K1_P, SECP256K1_P, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_c", c, '0);
        check("midrun_reset_ready", {{(W-1){1'b0}}, ready}, '0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        x = rand_word() % SECP256K1_P;
        y = rand_word() % SECP256K1_P;
        run_op(x, y, SECP256K1_P, 1'b1, "post_reset");

        repeat (3) @(negedge clk);
        check("pending_entries", W'(sb.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
